// File: rtl/pal_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pal_cfg_pkg
//  Description : Shared types and sizing helpers for the PAL configuration
//                path. The plane modules use the same sizing functions, so
//                every block agrees on the bitstream layout.
//                  - cfg_state_e : loader state encoding
//                  - and_bits()  : AND-plane bits (true+inverse per input/term)
//                  - or_bits()   : OR-plane bits (one per term per output)
//                  - total_bits(): full configuration word width
//  Revision    : 1.0 - initial release
// ============================================================================
package pal_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } cfg_state_e;

    function automatic int and_bits(input int n_in, input int n_terms);
        return 2 * n_in * n_terms;
    endfunction

    function automatic int or_bits(input int n_terms, input int n_out);
        return n_terms * n_out;
    endfunction

    function automatic int total_bits(input int n_in, input int n_terms, input int n_out);
        return and_bits(n_in, n_terms) + or_bits(n_terms, n_out);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pal_cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : pal_cfg_loader_if
//  Description : Serial configuration bus between the pin side (master) and
//                the configuration loader (slave).
//                  master -> slave : cfg_start, cfg_valid, cfg_data
//                  slave -> master : cfg_busy, cfg_done, cfg_ready,
//                                    cfg_conflict[N_TERMS], cfg_bits[BITS]
//  Revision    : 1.0 - initial release
// ============================================================================
interface pal_cfg_loader_if
    import pal_cfg_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 2
);
    localparam int BITS = total_bits(N_IN, N_TERMS, N_OUT);

    logic               cfg_start;
    logic               cfg_valid;
    logic               cfg_data;
    logic               cfg_busy;
    logic               cfg_done;
    logic               cfg_ready;
    logic [N_TERMS-1:0] cfg_conflict;
    logic [BITS-1:0]    cfg_bits;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_busy, cfg_done, cfg_ready, cfg_conflict, cfg_bits
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_busy, cfg_done, cfg_ready, cfg_conflict, cfg_bits
    );

endinterface
`default_nettype wire

// File: rtl/pal_term_check.sv
`default_nettype none
// ============================================================================
//  Module      : pal_term_check
//  Description : Combinational conflict detector for one AND-plane product
//                term. A term that selects both an input and its inverse is
//                constant 0, which is reported as a conflict.
//                  i_term     [2*N_IN] : bit 2i = input i true, 2i+1 = inverted
//                  o_conflict [1]      : any pair (2i, 2i+1) both set
//  Revision    : 1.0 - initial release
// ============================================================================
module pal_term_check #(
    parameter int N_IN = 4
) (
    input  wire logic [2*N_IN-1:0] i_term,
    output logic                   o_conflict
);

    always_comb begin
        o_conflict = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            o_conflict = o_conflict | (i_term[2*i] & i_term[2*i+1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pal_cfg_loader
//  Description : Serial PAL configuration writer. Shifts the bitstream into a
//                shadow register, checks one product term per cycle for
//                true/inverse conflicts, and commits a clean shadow word to
//                the active configuration atomically. The active word keeps
//                driving the planes while a new one is loaded and checked.
//                  clk, rst_n : clock, asynchronous active-low reset
//                  bus        : pal_cfg_loader_if.slave (start/valid/data in;
//                               busy/done/ready/conflict/bits out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 4,
    parameter int N_OUT   = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pal_cfg_loader_if.slave bus
);

    localparam int BITS   = total_bits(N_IN, N_TERMS, N_OUT);
    localparam int TERM_W = 2 * N_IN;
    localparam int CNT_W  = $clog2(BITS + 1);
    localparam int IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(BITS);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(N_TERMS - 1);

    cfg_state_e         r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [BITS-1:0]    r_shadow,   w_shadow_nxt;
    logic [IDX_W-1:0]   r_idx,      w_idx_nxt;
    // Set after the last term is scanned; the following CHECK cycle commits.
    logic               r_chk_fin,  w_chk_fin_nxt;
    logic [N_TERMS-1:0] r_conflict, w_conflict_nxt;
    logic [BITS-1:0]    r_bits,     w_bits_nxt;
    logic               r_ready,    w_ready_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_busy,     w_busy_nxt;

    logic [TERM_W-1:0]  w_term;
    logic               w_term_conflict;

    // Single checker shared across terms through the index mux.
    assign w_term = r_shadow[TERM_W*int'(r_idx) +: TERM_W];

    pal_term_check #(
        .N_IN (N_IN)
    ) u_term_check (
        .i_term     (w_term),
        .o_conflict (w_term_conflict)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shadow_nxt   = r_shadow;
        w_idx_nxt      = r_idx;
        w_chk_fin_nxt  = r_chk_fin;
        w_conflict_nxt = r_conflict;
        w_bits_nxt     = r_bits;
        w_ready_nxt    = r_ready;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // A data bit arriving with the start pulse is dropped.
                if (bus.cfg_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_cnt_nxt      = '0;
                    w_shadow_nxt   = '0;
                    w_conflict_nxt = '0;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    w_cnt_nxt      = '0;
                    w_shadow_nxt   = '0;
                    w_conflict_nxt = '0;
                end else if (bus.cfg_valid) begin
                    // New bits enter at the top so the first bit ends at 0.
                    w_shadow_nxt = {bus.cfg_data, r_shadow[BITS-1:1]};
                    if (r_cnt != c_cnt_max) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt   = ST_CHECK;
                        w_idx_nxt     = '0;
                        w_chk_fin_nxt = 1'b0;
                    end
                end
            end
            ST_CHECK: begin
                if (!r_chk_fin) begin
                    if (w_term_conflict) begin
                        w_conflict_nxt[r_idx] = 1'b1;
                    end
                    if (r_idx == c_idx_last) begin
                        w_chk_fin_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_done_nxt = 1'b1;
                    if (r_conflict == '0) begin
                        w_bits_nxt  = r_shadow;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_chk_fin  <= 1'b0;
            r_conflict <= '0;
            r_bits     <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shadow   <= w_shadow_nxt;
            r_idx      <= w_idx_nxt;
            r_chk_fin  <= w_chk_fin_nxt;
            r_conflict <= w_conflict_nxt;
            r_bits     <= w_bits_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.cfg_busy     = r_busy;
    assign bus.cfg_done     = r_done;
    assign bus.cfg_ready    = r_ready;
    assign bus.cfg_conflict = r_conflict;
    assign bus.cfg_bits     = r_bits;

endmodule
`default_nettype wire

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Serial configuration writer for the PAL fabric: accepts the programming bitstream one bit per cycle, assembles it in a shadow shift register, and checks every AND-plane product term for input/inverse conflicts. A clean bitstream is committed atomically to the active configuration register that feeds the AND/OR planes. It sits between the chip I/O pins and the plane logic, and is the producing end of the configuration bits that the product-term reducers consume.

## Interface
- N_IN, 4, number of PAL inputs; each product term has 2*N_IN config bits (true and inverted per input)
- N_TERMS, 4, number of product terms
- N_OUT, 2, number of OR-plane outputs
- Derived: AND_BITS = 2*N_IN*N_TERMS, OR_BITS = N_TERMS*N_OUT, BITS = AND_BITS+OR_BITS (default 40)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse that begins a new load
- cfg_valid  in  1  qualifies cfg_data for this cycle
- cfg_data  in  1  serial configuration bit
- cfg_busy  out  1  high in LOAD and CHECK
- cfg_done  out  1  one-cycle pulse at the end of CHECK, for either outcome
- cfg_ready  out  1  active register holds a validated configuration
- cfg_conflict  out  N_TERMS  per-term conflict mask from the last CHECK
- cfg_bits  out  BITS  active configuration driven to the planes

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE, DONE or ERROR with cfg_start:
  - go to LOAD
  - clear the bit counter and the shadow register
  - clear cfg_conflict
- LOAD:
  - Each cycle with cfg_valid high shifts cfg_data into shadow bit BITS-1, shifts the rest toward bit 0, and increments the counter.
  - The first bit sent ends at index 0.
  - When the BITS-th bit is accepted, go to CHECK.
- Bit layout:
  - Term t occupies [2*N_IN*t +: 2*N_IN].
  - Within a term, bit 2i is input i true and bit 2i+1 is input i inverted.
  - OR plane is [AND_BITS +: OR_BITS], with output o occupying [AND_BITS + N_TERMS*o +: N_TERMS].
- CHECK:
  - Runs N_TERMS cycles with term index k = 0..N_TERMS-1, one term per cycle.
  - cfg_conflict[k] is set if any pair (2i, 2i+1) of term k is both 1, because such a term is constant 0.
- After the last CHECK cycle:
  - No conflict: copy shadow to cfg_bits, set cfg_ready=1, go to DONE.
  - Any conflict: leave cfg_bits unchanged, go to ERROR. cfg_ready keeps its previous value.
- cfg_done pulses on entry to DONE or ERROR.
- The active configuration keeps driving the planes throughout LOAD and CHECK (double-buffered).
- Boundary rules:
  - cfg_start during LOAD restarts the load: counter and shadow are cleared, and cfg_valid in that cycle is ignored.
  - cfg_start and cfg_valid in the same cycle in IDLE/DONE/ERROR: start wins and the data bit is dropped.
  - cfg_start during CHECK is ignored.
  - cfg_valid outside LOAD is ignored.
  - The counter saturates; it never wraps past BITS.
- Reset (any time, including mid-LOAD or mid-CHECK):
  - state IDLE
  - cfg_bits = 0, cfg_ready = 0, cfg_conflict = 0
  - cfg_busy = 0, cfg_done = 0

## Timing
- All outputs are registered.
- The accept cycle for each bit is the edge where cfg_valid=1 in LOAD. cfg_busy rises the cycle after cfg_start.
- If the last bit is accepted at edge T:
  - CHECK occupies edges T+1 .. T+N_TERMS.
  - cfg_done, cfg_bits, cfg_ready and the final cfg_conflict become visible after edge T+N_TERMS+1.
  - Default latency is 5 cycles.
- Minimum load time is BITS + N_TERMS + 2 cycles from cfg_start. Gaps in cfg_valid extend it one cycle per gap.
- Counter width is $clog2(BITS+1). The term index width is $clog2(N_TERMS), minimum 1.

## Structure
- Shared package pal_cfg_pkg holds:
  - the state enum
  - functions computing AND_BITS, OR_BITS and BITS from N_IN/N_TERMS/N_OUT, shared with the plane modules
- One sub-module, pal_term_check: combinational, input 2*N_IN bits, output 1 conflict bit.
  - Instantiated once and fed by a term-index mux over the shadow register.

## Test plan
- Reset mid-LOAD after 17 bits:
  - all outputs 0 and state IDLE.
  - A new start plus 40 bits then loads cleanly.
- Default params, cfg_start, 40 bits with only bit 0 and bit 39 set, no gaps:
  - cfg_done pulses exactly 5 cycles after the last bit.
  - cfg_bits = 40'h80_0000_0001, cfg_ready=1, cfg_conflict=0.
- Term 2 has bits 16 and 17 both 1:
  - ERROR, cfg_conflict=4'b0100, cfg_done pulses.
  - cfg_bits and cfg_ready keep their prior values.
- cfg_valid toggling every other cycle for 40 bits:
  - Same cfg_bits as the contiguous load.
  - cfg_busy stays high throughout.
- cfg_start after 10 bits, then 40 new bits:
  - Only the new 40 bits appear in cfg_bits.
  - The old active config stays visible until commit.
- cfg_start pulsed during CHECK:
  - Ignored; commit completes normally.
- Separately, cfg_start and cfg_valid=1 in the same cycle from DONE:
  - The bit is dropped.
  - cfg_done arrives only after 40 further accepted bits.
